verin_bp_debounce: RTL and testbench

//  Conditions the raw actuator push-button (bp) pad before it reaches the Avalon PIO
//  in_port. Synchronises the asynchronous pad, debounces it with a stability counter,
//  and outputs a clean level plus single-cycle press/release pulses. Sits between the

---
 rtl/verin_pkg.sv | 19 +
 rtl/verin_sync.sv | 30 +++
 rtl/verin_bp_debounce.sv | 185 ++++++++++++++++++
 tb/tb_verin_bp_debounce.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/verin_pkg.sv
// Shared definitions for the verin pad-conditioning blocks.
//  bp_state_t    : debounce FSM state encoding
//  ms_to_cycles  : converts a millisecond interval to clock cycles, never below 1
package verin_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } bp_state_t;

  function automatic int ms_to_cycles(input int freq, input int ms);
    int c;
    c = (freq / 1000) * ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/verin_sync.sv
// Generic N-flop synchroniser for asynchronous pad inputs.
// Parameters: STAGES (number of flops, >= 2), RESET_VAL (value loaded on reset).
// Ports:
//  clk    in  system clock
//  reset  in  synchronous active-high reset, loads RESET_VAL into every stage
//  i_d    in  asynchronous input
//  o_q    out synchronised output (last stage)
module verin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/verin_bp_debounce.sv
// Push-button conditioner: synchronises the raw bp pad, debounces it with a
// stability counter and produces a clean level plus one-cycle press/release pulses.
// Optional feature macro: VERIN_BP_LONGPRESS_EN adds a long-press pulse on bp_long;
// without it bp_long is constant 0 and no long counter exists.
// Ports:
//  clk         in   system clock, rising edge
//  reset       in   synchronous active-high reset
//  bp_pad      in   raw asynchronous push-button pin
//  bp_level    out  debounced level, 1 = pressed
//  bp_press    out  one-cycle pulse when a press is accepted
//  bp_release  out  one-cycle pulse when a release is accepted
//  bp_long     out  one-cycle long-press pulse (0 when feature compiled out)
module verin_bp_debounce #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic bp_pad,
  output logic bp_level,
  output logic bp_press,
  output logic bp_release,
  output logic bp_long
);

  import verin_pkg::*;

  localparam int   DB_CYCLES    = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int   CNT_W        = $clog2(DB_CYCLES + 1);
  localparam int   LONG_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
  localparam logic PAD_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // The sample that moves the FSM out of a stable state is the first of the
  // DB_CYCLES required samples, so inside a WAIT state the counter holds
  // (stable samples - 1) and acceptance happens when it reaches DB_CYCLES-2.
  // This keeps the total latency at SYNC_STAGES + DB_CYCLES edges.
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'((DB_CYCLES >= 2) ? DB_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DB_CYCLES - 1);

  logic      w_sync_q;
  logic      w_s;
  bp_state_t r_state;
  bp_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic      r_level;
  logic      w_level_nxt;
  logic      r_press;
  logic      w_press_nxt;
  logic      r_release;
  logic      w_release_nxt;

  verin_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (PAD_RELEASED)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bp_pad),
    .o_q   (w_sync_q)
  );

  // Normalise polarity after the last synchroniser stage: w_s = 1 means pressed.
  assign w_s = (ACTIVE_LOW != 0) ? ~w_sync_q : w_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_cnt_nxt = '0;
          if (DB_CYCLES == 1) begin
            w_state_nxt = PRESSED;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT_PRESS;
          end
        end
      end
      WAIT_PRESS: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_ACCEPT) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_cnt_nxt = '0;
          if (DB_CYCLES == 1) begin
            w_state_nxt   = RELEASED;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT_RELEASE;
          end
        end
      end
      WAIT_RELEASE: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_ACCEPT) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bp_level   = r_level;
  assign bp_press   = r_press;
  assign bp_release = r_release;

`ifdef VERIN_BP_LONGPRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_FIRE = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] r_long_cnt;
  logic              r_long;

  // Counts cycles spent in PRESSED that stay in PRESSED; saturating at
  // LONG_CYCLES guarantees a single pulse per stay.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_long_cnt <= '0;
      r_long     <= 1'b0;
    end else if (r_state == PRESSED && w_s) begin
      if (r_long_cnt != LONG_MAX) begin
        r_long_cnt <= r_long_cnt + 1'b1;
      end
      r_long <= (r_long_cnt == LONG_FIRE);
    end else begin
      r_long_cnt <= '0;
      r_long     <= 1'b0;
    end
  end

  assign bp_long = r_long;
`else
  // ms_to_cycles never returns less than 1, so this is constant 0; it keeps
  // LONG_CYCLES referenced in the build without the long-press feature.
  assign bp_long = (LONG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_verin_bp_debounce.sv
module tb_verin_bp_debounce;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int DEBOUNCE_MS = 5;
  localparam int SYNC_STAGES = 2;
  localparam int ACTIVE_LOW  = 1;
  localparam int LONG_MS     = 20;
  localparam int DB          = 5;   // 1000/1000*5
  localparam int LONG_C      = 20;  // 1000/1000*20
  localparam int MAXE        = 8192;
`ifdef VERIN_BP_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bp_pad;
  logic bp_level, bp_press, bp_release, bp_long;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  verin_bp_debounce #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .SYNC_STAGES (SYNC_STAGES),
    .ACTIVE_LOW  (ACTIVE_LOW),
    .LONG_MS     (LONG_MS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bp_pad     (bp_pad),
    .bp_level   (bp_level),
    .bp_press   (bp_press),
    .bp_release (bp_release),
    .bp_long    (bp_long)
  );

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: history of "pressed" pad samples per edge (reset edges
  // recorded as released). The FSM sees the pad SYNC_STAGES edges late; the
  // level flips when the last DB seen samples all agree and differ from it.
  bit hist [MAXE];
  int k = 0;
  bit m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;
  int entry = -1;

  function automatic bit seen(input int e);
    return (e >= 0) ? hist[e] : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit s, sp, stable;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (k < MAXE) begin
      if (reset) begin
        hist[k] = 1'b0;
        m_level = 1'b0;
        entry   = -1;
      end else begin
        hist[k] = (ACTIVE_LOW != 0) ? ~bp_pad : bp_pad;
        s  = seen(k - SYNC_STAGES);
        sp = seen(k - 1 - SYNC_STAGES);
        stable = 1'b1;
        for (int j = 0; j < DB; j++)
          if (seen(k - SYNC_STAGES - j) != s) stable = 1'b0;
        if (stable && s != m_level) begin
          m_level = s;
          m_press = s;
          m_rel   = ~s;
          entry   = s ? k : -1;
        end else if (m_level && !s) begin
          entry = -1;
        end else if (m_level && s && !sp) begin
          entry = k;
        end
        if (m_level && entry >= 0 && (k - entry) == LONG_C) m_long = 1'b1;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", bp_level, m_level);
      chk("press", bp_press, m_press);
      chk("release", bp_release, m_rel);
      chk("long", bp_long, LONG_EN ? m_long : 1'b0);
      chk("press_and_release", bp_press & bp_release, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold;
    // Reset held with the pad pressed: outputs stay 0, press after 7 edges.
    reset  = 1'b1;
    bp_pad = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    chk("t1 reset level", bp_level, 1'b0);
    chk("t1 reset press", bp_press, 1'b0);
    reset = 1'b0;
    repeat (6) tick();
    chk("t1 level before edge 7", bp_level, 1'b0);
    tick();
    chk("t1 press at edge 7", bp_press, 1'b1);
    chk("t1 level at edge 7", bp_level, 1'b1);
    chk("t1 model press at edge 7", m_press, 1'b1);
    tick();
    chk("t1 press one cycle", bp_press, 1'b0);
    repeat (20) tick();

    // Release after press.
    bp_pad = 1'b1;
    repeat (6) tick();
    chk("t5 level before edge 7", bp_level, 1'b1);
    tick();
    chk("t5 release at edge 7", bp_release, 1'b1);
    chk("t5 level at edge 7", bp_level, 1'b0);
    chk("t5 model release", m_rel, 1'b1);
    repeat (10) tick();

    // Clean press held 30 cycles; long-press pulse 20 cycles after press.
    bp_pad = 1'b0;
    repeat (6) tick();
    chk("t2 press early", bp_press, 1'b0);
    tick();
    chk("t2 press at edge 7", bp_press, 1'b1);
    chk("t2 level", bp_level, 1'b1);
    repeat (19) tick();
    chk("t6 long before 20", bp_long, 1'b0);
    tick();
    chk("t6 long at 20", bp_long, LONG_EN);
    chk("t6 model long at 20", m_long, 1'b1);
    tick();
    chk("t6 long one cycle", bp_long, 1'b0);
    repeat (3) tick();
    bp_pad = 1'b1;
    repeat (15) tick();
    chk("t2 released again", bp_level, 1'b0);

    // Bounce: toggles every 2 cycles for 12 cycles, then settles pressed.
    for (int i = 0; i < 12; i++) begin
      bp_pad = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk("t3 no press during bounce", bp_level, 1'b0);
    end
    bp_pad = 1'b0;
    repeat (6) tick();
    chk("t3 level before edge 7", bp_level, 1'b0);
    tick();
    chk("t3 single press", bp_press, 1'b1);
    repeat (10) tick();
    bp_pad = 1'b1;
    repeat (15) tick();

    // Glitch: 4-cycle low pulse ignored, 5-cycle pulse accepted.
    bp_pad = 1'b0;
    repeat (4) tick();
    bp_pad = 1'b1;
    repeat (12) tick();
    chk("t4 4-cycle glitch ignored", bp_level, 1'b0);
    bp_pad = 1'b0;
    repeat (5) tick();
    bp_pad = 1'b1;
    tick();
    chk("t4 level before edge 7", bp_level, 1'b0);
    tick();
    chk("t4 5-cycle pulse press", bp_press, 1'b1);
    repeat (20) tick();
    chk("t4 released after pulse", bp_level, 1'b0);

    // Reset in the middle of WAIT_PRESS discards the partial count.
    bp_pad = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("t7 level before full latency", bp_level, 1'b0);
    tick();
    chk("t7 press after full latency", bp_press, 1'b1);
    bp_pad = 1'b1;
    repeat (15) tick();

    // Randomized phase against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(2, 3)) tick();
        reset = 1'b0;
      end
      bp_pad = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
      repeat (hold) tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
